key_press_conditioner: RTL and testbench
========================================

// Module: key_press_conditioner
// PURPOSE
//   Converts one raw, asynchronous, bouncing pushbutton into a clean one-cycle press pulse.
//   The pulse drives the keyPress input of the 2-bit game counter.
//   Path: 2-FF synchronizer -> polarity fix -> debounce FSM -> pulse gate (gameStart).
//   One instance per board KEY.
// PARAMETERS
//   ACTIVE_LOW       1  1: keyRaw=0 means pressed (DE1 KEYs); 0: keyRaw=1 means pressed
//   DEBOUNCE_CYCLES  4  consecutive stable synchronized samples needed to accept a press/release (>=2)
//   REPEAT_CYCLES    8  auto-repeat period in HELD (used only with KEY_REPEAT_EN; >=2)
// PORTS
//   Clock      in   1  single system clock, posedge
//   Reset      in   1  asynchronous, active-high; clears all state
//   keyRaw     in   1  raw pushbutton, asynchronous to Clock
//   gameStart  in   1  pulse enable; FSM tracks the key regardless
//   keyPress   out  1  registered one-cycle pulse per accepted press
//   keyLevel   out  1  registered debounced level (1 = pressed)
// BEHAVIOUR
//   - Reset (async): sync flops <= released value; state <= IDLE; cnt <= 0.
//     keyPress=0 and keyLevel=0 immediately, with no clock edge required.
//   - keyS = sync2 ^ ACTIVE_LOW (1 = pressed). sync1 samples keyRaw; sync2 <= sync1.
//   - cnt width = $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)); cnt never wraps.
//   - FSM (registered state):
//     IDLE:     keyS=1 -> PRESS_WAIT, cnt<=0.
//     PRESS_WAIT: keyS=0 -> IDLE.
//                 cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, keyPress<=gameStart.
//                 else cnt++.
//     HELD:     keyS=0 -> RELEASE_WAIT, cnt<=0.
//     RELEASE_WAIT: keyS=1 -> HELD, no pulse.
//                   cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//                   else cnt++.
//   - keyPress is 1 for exactly the cycle after entry to HELD; 0 in every other cycle.
//   - keyLevel=1 in HELD and RELEASE_WAIT, else 0.
//   - Latency: press first sampled at edge 0 -> keyPress/keyLevel high after edge DEBOUNCE_CYCLES+2 (6 at default).
//   - Bounce shorter than DEBOUNCE_CYCLES restarts qualification; a bounce never produces a pulse.
//   - gameStart=0: no pulses, FSM still advances.
//     A key already held when gameStart rises gives no pulse until it is released and pressed again.
//   - gameStart sampled only on the HELD-entry edge.
//   - Reset asserted mid-qualification: partial count discarded. After deassert, press restarts from IDLE.
// CONFIGURATION
//   KEY_REPEAT_EN defined:
//     In HELD, cnt counts; at cnt==REPEAT_CYCLES-1: cnt<=0, keyPress<=gameStart.
//     Pulses every REPEAT_CYCLES while held. Leaving HELD clears cnt.
//   KEY_REPEAT_EN undefined:
//     No repeat logic; cnt is idle in HELD; REPEAT_CYCLES ignored; exactly one pulse per press.
// STRUCTURE
//   Package key_cond_pkg:
//     typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t
//     localparam KEY_SYNC_STAGES = 2
//   Sub-module sync_2ff: 2-flop synchronizer with async reset and reset-value parameter.
//   FSM, counter and output registers live in key_press_conditioner.
// TESTING (defaults ACTIVE_LOW=1, D=4, R=8; edge 0 = first sample of new keyRaw)
//   1. Reset=1, keyRaw=1 -> keyPress=0, keyLevel=0; stays so 10 cycles after Reset=0.
//   2. gameStart=1; keyRaw 1->0 held 12 cycles -> single keyPress pulse after edge 6.
//      keyLevel 1 from edge 6; keyRaw->1 -> keyLevel 0 after edge 6 of release.
//   3. keyRaw low 2, high 1, low 10 -> exactly one pulse, 6 edges after last falling keyRaw.
//   4. gameStart=0 during full press -> no pulse.
//      gameStart 0->1 while held -> no pulse; release + repress -> one pulse.
//   5. Reset pulsed (between edges) during PRESS_WAIT -> outputs 0 without clock.
//      Post-reset clean press -> one pulse at edge 6.
//   6. KEY_REPEAT_EN defined, key held 30 cycles -> pulses after edges 6, 14, 22, 30.
//      Undefined -> pulse after edge 6 only.

Source files
------------

// File: rtl/key_cond_pkg.sv
// ---------------------------------------------------------------------------
// key_cond_pkg
//   Shared types and constants for the pushbutton conditioner.
//   - key_state_t     : debounce FSM states
//   - KEY_SYNC_STAGES : depth of the metastability synchronizer
//   - max_int()       : elaboration-time helper for sizing the shared counter
// ---------------------------------------------------------------------------
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int KEY_SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_press_conditioner_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Flop-chain synchronizer for one asynchronous bit (two stages by default).
//   The first stage samples i_d; each later stage samples its predecessor.
//   All stages load RESET_VAL on the asynchronous reset so the output
//   comes up in a known, harmless state.
// Ports
//   i_clock  in   system clock, posedge
//   i_reset  in   asynchronous, active-high reset
//   i_d      in   asynchronous input bit
//   o_q      out  synchronized bit (last stage)
// ---------------------------------------------------------------------------
module sync_2ff
  import key_cond_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter int   STAGES    = KEY_SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] w_sync_d;

  // Build the input of every stage: stage 0 takes the raw bit, the rest
  // take the previous stage.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_sync_d[gi] = i_d;
      end else begin : g_chain
        assign w_sync_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= w_sync_d;
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_press_conditioner.sv
// ---------------------------------------------------------------------------
// key_press_conditioner
//   Turns one raw, bouncing pushbutton into a clean one-cycle press pulse
//   plus a debounced level. Path: synchronizer -> polarity fix ->
//   debounce FSM -> pulse gate (i_game_start).
// Parameters
//   ACTIVE_LOW       1: raw 0 means pressed; 0: raw 1 means pressed
//   DEBOUNCE_CYCLES  stable synchronized samples to accept press/release (>=2)
//   REPEAT_CYCLES    auto-repeat period while held (>=2, repeat build only)
// Ports
//   i_clock       in   system clock, posedge
//   i_reset       in   asynchronous, active-high reset; clears all state
//   i_key_raw     in   raw pushbutton, asynchronous to i_clock
//   i_game_start  in   pulse enable; the FSM tracks the key regardless
//   o_key_press   out  registered one-cycle pulse per accepted press
//   o_key_level   out  registered debounced level (1 = pressed)
// Configuration
//   KEY_REPEAT_EN  when defined, a held key re-pulses every REPEAT_CYCLES.
//                  When undefined, exactly one pulse per press.
// ---------------------------------------------------------------------------
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_key_raw,
  input  logic i_game_start,
  output logic o_key_press,
  output logic o_key_level
);

  // One counter serves both debounce qualification and auto-repeat, so it
  // is sized for the larger of the two periods and is never allowed to wrap.
  localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Raw pin value while the button is not pressed.
  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

  logic             w_sync;
  logic             w_key_s;

  key_state_t       r_state;
  key_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_key_press;
  logic             w_press_next;
  logic             r_key_level;
  logic             w_level_next;

  // Reset the synchronizer to the released pin value so no phantom press
  // is seen while the chain refills after reset.
  sync_2ff #(
    .RESET_VAL (RELEASED_RAW),
    .STAGES    (KEY_SYNC_STAGES)
  ) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_key_raw),
    .o_q     (w_sync)
  );

  // Normalize polarity: 1 = pressed.
  assign w_key_s = w_sync ^ RELEASED_RAW;

  // -------------------------------------------------------------------------
  // State, counter and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_press <= 1'b0;
      r_key_level <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_key_press <= w_press_next;
      r_key_level <= w_level_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / counter / pulse logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_press_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_key_s) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_key_s) begin
          // A bounce discards the partial qualification.
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = HELD;
          w_cnt_next   = '0;
          // The enable is only looked at here, so a key already held when
          // the game starts never produces a late pulse.
          w_press_next = i_game_start;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      HELD: begin
        if (!w_key_s) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (r_cnt == REP_LAST) begin
            w_cnt_next   = '0;
            w_press_next = i_game_start;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
`else
          w_cnt_next = r_cnt;
`endif
        end
      end

      RELEASE_WAIT: begin
        if (w_key_s) begin
          // Release bounce: back to HELD without a new pulse.
          w_state_next = HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Level follows the state being entered, so it is registered alongside
    // the state itself and rises on the same edge as the press pulse.
    w_level_next = (w_state_next == HELD) || (w_state_next == RELEASE_WAIT);
  end

  assign o_key_press = r_key_press;
  assign o_key_level = r_key_level;

endmodule

// File: tb/tb_key_press_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_press_conditioner
//   Scoreboard bench: expected press-pulse cycles are queued when a press is
//   driven and popped when the DUT raises o_key_press. Level and reset
//   behaviour are checked directly at known cycles.
//   Timing reference: raw is changed on a negedge; the next posedge is
//   "edge 0"; a pulse after edge k is visible at the negedge where the
//   posedge counter equals edge0 + k.
// ---------------------------------------------------------------------------
module tb_key_press_conditioner;

  localparam int D = 4;
  localparam int R = 8;
`ifdef KEY_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic key_raw   = 1'b1;
  logic game_start = 1'b0;
  logic key_press;
  logic key_level;

  int cyc = 0;
  int exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  key_press_conditioner #(
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_key_raw    (key_raw),
    .i_game_start (game_start),
    .o_key_press  (key_press),
    .o_key_level  (key_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every observed pulse must match the oldest
  // expected cycle.
  always @(negedge clk) begin
    if (key_press === 1'b1) begin
      if (exp_q.size() == 0) begin
        $display("pulse at cycle %0d (none expected)", cyc);
        check("pulse_unexpected", cyc, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("pulse at cycle %0d expected %0d", cyc, e);
        check("pulse_cycle", cyc, e);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the pulses a press of 'hold' raw samples should give, from the
  // latency rule (edge D+2) and the repeat period. The key still counts as
  // held at posedge p when p <= edge0 + hold + 1 (two-flop delay).
  task automatic push_pulses(input int e0, input int hold);
    if (game_start) begin
      for (int p = D + 2; p <= hold + 1; p += R) begin
        exp_q.push_back(e0 + p);
        if (REP_ON == 0) break;
      end
    end
  endtask

  // Clean press of 'hold' cycles (hold >= 7), with level checks around
  // the press and the release, then settle back to IDLE.
  task automatic do_press(input int hold, input string tag);
    int e0;
    int e0r;
    key_raw = 1'b0;
    e0 = cyc + 1;
    push_pulses(e0, hold);
    wait_n(D + 2);
    check({tag, "_lvl_before_accept"}, key_level, 0);
    wait_n(1);
    check({tag, "_lvl_after_accept"}, key_level, 1);
    wait_n(hold - (D + 3));
    key_raw = 1'b1;
    e0r = cyc + 1;
    wait_n(D + 2);
    check({tag, "_lvl_before_release"}, key_level, 1);
    wait_n(1);
    check({tag, "_lvl_after_release"}, key_level, 0);
    wait_n(4);
  endtask

  initial begin
    // 1. Asynchronous reset, no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("rst_press_noclk", key_press, 0);
    check("rst_level_noclk", key_level, 0);
    wait_n(3);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_n(1);
      check("post_rst_level", key_level, 0);
    end

    // 2. Single clean press with the game running.
    game_start = 1'b1;
    do_press(12, "t2");

    // 3a. Bounce shorter than the debounce window: no pulse.
    key_raw = 1'b0;
    wait_n(3);
    key_raw = 1'b1;
    wait_n(10);
    check("t3_short_bounce_lvl", key_level, 0);

    // 3b. low 2, high 1, low 10: one pulse 6 edges after last fall.
    key_raw = 1'b0;
    wait_n(2);
    key_raw = 1'b1;
    wait_n(1);
    key_raw = 1'b0;
    push_pulses(cyc + 1, 10);
    wait_n(10);
    check("t3_bounce_held_lvl", key_level, 1);
    key_raw = 1'b1;
    wait_n(10);
    check("t3_bounce_rel_lvl", key_level, 0);

    // 4a. Game not started: FSM runs, no pulse.
    game_start = 1'b0;
    do_press(12, "t4a");

    // 4b. Game starts while key is already held: no pulse.
    key_raw = 1'b0;
    wait_n(9);
    check("t4b_held_lvl", key_level, 1);
    game_start = 1'b1;
    wait_n(3);
    key_raw = 1'b1;
    wait_n(10);

    // 4c. Release + repress with game running: one pulse.
    do_press(12, "t4c");

    // 5a. Reset between edges during PRESS_WAIT with the key still down:
    //     the partial count is dropped and qualification restarts.
    key_raw = 1'b0;
    wait_n(4);
    #1 rst = 1'b1;
    #1;
    check("t5a_rst_press", key_press, 0);
    check("t5a_rst_level", key_level, 0);
    #1 rst = 1'b0;
    exp_q.push_back(cyc + 1 + D + 2);
    @(negedge clk);
    wait_n(D + 3);
    check("t5a_restart_lvl", key_level, 1);
    key_raw = 1'b1;
    wait_n(10);

    // 5b. Reset while HELD: level drops immediately without a clock edge.
    key_raw = 1'b0;
    push_pulses(cyc + 1, 8);
    wait_n(8);
    check("t5b_held_lvl", key_level, 1);
    #1 rst = 1'b1;
    #1;
    check("t5b_rst_level", key_level, 0);
    key_raw = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    wait_n(10);
    check("t5b_after_lvl", key_level, 0);

    // 5c. Clean press after reset.
    do_press(12, "t5c");

    // 6. Long hold: repeat pulses only in the repeat build.
    do_press(30, "t6");

    wait_n(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
